// File: rtl/accumulator_bank_pkg.sv
// Shared types and helpers for the accumulator bank: FSM states, store-mode
// encodings and the saturate/truncate conversion used on every output beat.
package accumulator_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REDUCE = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  localparam logic MODE_COLUMN = 1'b0;
  localparam logic MODE_REDUCE = 1'b1;

  // Values arrive sign-extended to 64 bits so one helper serves any ACC_W <= 64.
  function automatic logic signed [63:0] conv_val(input logic signed [63:0] v,
                                                  input int dw,
                                                  input logic sat_en);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sat_en && (v > hi)) return hi;
    if (sat_en && (v < lo)) return lo;
    return v;
  endfunction

  function automatic logic conv_clamps(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/accumulator_bank_acc_lane.sv
// One column of the bank: live signed accumulator plus its snapshot register.
module acc_lane #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] lane_i,
  input  logic              clear_i,
  input  logic              snap_en_i,
  output logic [ACC_W-1:0]  snap_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] snap_q, snap_d;
  logic [ACC_W-1:0] lane_ext;
  logic [ACC_W-1:0] sum;

  assign lane_ext = in_valid_i ? ACC_W'($signed(lane_i)) : '0;
  assign sum      = acc_q + lane_ext;

  // A clear (explicit or from a store) restarts the window with this cycle's beat.
  always_comb begin
    acc_d  = clear_i ? lane_ext : sum;
    snap_d = snap_en_i ? sum : snap_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      snap_q <= '0;
    end else begin
      acc_q  <= acc_d;
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/accumulator_bank.sv
// Column accumulator bank with double-buffered snapshot and valid/ready drain.
// Optional clamp-on-output with sticky ovf: define ACCUMULATOR_BANK_SAT_EN.
module accumulator_bank
  import accumulator_bank_pkg::*;
#(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 40,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic [ARR_SIZE*DATA_W-1:0] in_data_i,
  input  logic                       acc_clear_i,
  input  logic                       store_req_i,
  input  logic                       store_mode_i,
  input  logic [ADDR_W-1:0]          store_addr_i,
  output logic                       store_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [ADDR_W-1:0]          out_addr_o,
  output logic                       busy_o,
  output logic                       ovf_o
);

  localparam int IDX_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARR_SIZE - 1);

`ifdef ACCUMULATOR_BANK_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ACC_W-1:0]   red_q, red_d;
  logic               out_valid_q, out_valid_d;
  logic               store_accept;
  logic [ACC_W-1:0]   snap_w [ARR_SIZE];
  logic [ACC_W-1:0]   sel_acc;
  logic signed [63:0] sel_ext;

  assign store_accept = store_req_i && (state_q == ST_IDLE);

  for (genvar g = 0; g < ARR_SIZE; g++) begin : g_lane
    acc_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid_i),
      .lane_i     (in_data_i[g*DATA_W +: DATA_W]),
      .clear_i    (acc_clear_i | store_accept),
      .snap_en_i  (store_accept),
      .snap_o     (snap_w[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    red_d       = red_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (store_accept) begin
          base_d = store_addr_i;
          idx_d  = '0;
          red_d  = '0;
          if (store_mode_i == MODE_REDUCE) begin
            state_d = ST_REDUCE;
          end else begin
            state_d     = ST_DRAIN;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready_i) begin
          if (idx_q == IDX_LAST) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_REDUCE: begin
        red_d = red_q + snap_w[idx_q];
        if (idx_q == IDX_LAST) begin
          state_d     = ST_EMIT;
          out_valid_d = 1'b1;
          idx_d       = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_EMIT: begin
        if (out_ready_i) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      red_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      red_q       <= red_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Beat payload is a pure function of held state, so it stays put under backpressure.
  assign sel_acc = (state_q == ST_EMIT) ? red_q : snap_w[idx_q];
  assign sel_ext = 64'($signed(sel_acc));

  assign out_data_o    = DATA_W'(conv_val(sel_ext, DATA_W, SAT_ON));
  assign out_addr_o    = (state_q == ST_EMIT) ? base_q : base_q + ADDR_W'(idx_q);
  assign out_valid_o   = out_valid_q;
  assign store_ready_o = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);

`ifdef ACCUMULATOR_BANK_SAT_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (out_valid_q & conv_clamps(sel_ext, DATA_W));
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_bank.sv
// Randomized self-checking bench for accumulator_bank against a queue-based
// behavioural model; honours ACCUMULATOR_BANK_SAT_EN for expected values.
module tb_accumulator_bank;

  localparam int ARR = 4;
  localparam int DW  = 32;
  localparam int AW  = 40;
  localparam int ADW = 4;
  localparam longint MASK = 64'sh00FF_FFFF_FFFF;
  localparam longint LMAX = 64'sh7FFF_FFFF;
  localparam longint LMIN = -64'sh8000_0000;
`ifdef ACCUMULATOR_BANK_SAT_EN
  localparam bit SAT_M = 1'b1;
`else
  localparam bit SAT_M = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [ARR*DW-1:0] in_data;
  logic              acc_clear;
  logic              store_req;
  logic              store_mode;
  logic [ADW-1:0]    store_addr;
  logic              store_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [ADW-1:0]    out_addr;
  logic              busy;
  logic              ovf;

  accumulator_bank #(
    .ARR_SIZE (ARR),
    .DATA_W   (DW),
    .ACC_W    (AW),
    .ADDR_W   (ADW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .acc_clear_i   (acc_clear),
    .store_req_i   (store_req),
    .store_mode_i  (store_mode),
    .store_addr_i  (store_addr),
    .store_ready_o (store_ready),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_addr_o    (out_addr),
    .busy_o        (busy),
    .ovf_o         (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic [DW-1:0]  d;
    logic [ADW-1:0] a;
    bit             clamp;
  } beat_t;

  longint acc_m [ARR];
  beat_t  q_m [$];
  bit     busy_m;
  bit     ovf_m;
  int     valid_from;
  int     cyc = 0;

  function automatic longint sx40(input longint v);
    longint t;
    t = v & MASK;
    if (t[AW-1]) t = t - (64'sd1 <<< AW);
    return t;
  endfunction

  function automatic beat_t mk_beat(input longint a40, input logic [ADW-1:0] addr);
    beat_t  b;
    longint v;
    v       = sx40(a40);
    b.a     = addr;
    b.clamp = (v > LMAX) || (v < LMIN);
    if (SAT_M && v > LMAX) v = LMAX;
    if (SAT_M && v < LMIN) v = LMIN;
    b.d = v[DW-1:0];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ARR; k++) acc_m[k] = 0;
    q_m.delete();
    busy_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check held outputs, advance model, move to next negedge.
  task automatic step(input logic iv, input logic [ARR*DW-1:0] d, input logic clr,
                      input logic sreq, input logic smode, input logic [ADW-1:0] sadr,
                      input logic ordy);
    bit             ev, accept, hs;
    longint         snap [ARR];
    longint         s, sum;
    logic [ADW-1:0] a;
    in_valid   = iv;
    in_data    = d;
    acc_clear  = clr;
    store_req  = sreq;
    store_mode = smode;
    store_addr = sadr;
    out_ready  = ordy;
    #1;
    ev = busy_m && (cyc >= valid_from);
    chk("store_ready", 64'(store_ready), 64'(!busy_m));
    chk("busy", 64'(busy), 64'(busy_m));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("ovf", 64'(ovf), 64'(ovf_m));
    if (ev) begin
      chk("out_data", 64'(out_data), 64'(q_m[0].d));
      chk("out_addr", 64'(out_addr), 64'(q_m[0].a));
      if (SAT_M && q_m[0].clamp) ovf_m = 1'b1;
    end
    accept = !busy_m && sreq;
    hs     = ev && ordy;
    if (hs) begin
      void'(q_m.pop_front());
      if (q_m.size() == 0) busy_m = 1'b0;
    end
    for (int k = 0; k < ARR; k++) begin
      s = iv ? longint'($signed(d[k*DW +: DW])) : 64'sd0;
      if (accept) begin
        snap[k]  = (acc_m[k] + s) & MASK;
        acc_m[k] = s & MASK;
      end else if (clr) begin
        acc_m[k] = s & MASK;
      end else begin
        acc_m[k] = (acc_m[k] + s) & MASK;
      end
    end
    if (accept) begin
      busy_m = 1'b1;
      if (smode == 1'b0) begin
        for (int i = 0; i < ARR; i++) begin
          a = sadr + ADW'(i);
          q_m.push_back(mk_beat(snap[i], a));
        end
        valid_from = cyc + 1;
      end else begin
        sum = 0;
        for (int i = 0; i < ARR; i++) sum = sum + snap[i];
        q_m.push_back(mk_beat(sum, sadr));
        valid_from = cyc + 1 + ARR;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_drain();
    for (int i = 0; i < 40 && busy_m; i++) step(0, '0, 0, 0, 0, '0, 1);
    if (busy_m) chk("drain_timeout", 64'(busy), 64'(0));
    step(0, '0, 0, 0, 0, '0, 1);
  endtask

  logic [ARR*DW-1:0] lanes_k1;
  logic [ARR*DW-1:0] lanes_big;
  logic [ARR*DW-1:0] rnd;

  initial begin
    lanes_k1  = {32'd4, 32'd3, 32'd2, 32'd1};
    lanes_big = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
    rst = 1'b1;
    in_valid = 0; in_data = '0; acc_clear = 0; store_req = 0;
    store_mode = 0; store_addr = '0; out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_store_ready", 64'(store_ready), 64'(1));
    rst = 1'b0;
    step(0, '0, 0, 0, 0, '0, 1);

    // Per-column drain, base 2: 3,6,9,12 at 2..5
    repeat (3) step(1, lanes_k1, 0, 0, 0, '0, 1);
    step(0, '0, 0, 1, 0, 4'd2, 1);
    idle_drain();

    // Reduced sum, base 14: single 30
    repeat (3) step(1, lanes_k1, 0, 0, 0, '0, 1);
    step(0, '0, 0, 1, 1, 4'd14, 1);
    idle_drain();

    // Address wrap with stalls
    repeat (3) step(1, lanes_k1, 0, 0, 0, '0, 1);
    step(0, '0, 0, 1, 0, 4'd14, 1);
    step(0, '0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 0, '0, 1);
    idle_drain();

    // Beat on accept cycle, clear+beat next cycle, stores during drain ignored
    step(1, {4{32'd5}}, 0, 1, 0, 4'd0, 1);
    step(1, {4{32'd7}}, 1, 1, 1, 4'd9, 1);
    step(0, '0, 0, 1, 1, 4'd9, 0);
    idle_drain();
    step(0, '0, 0, 1, 0, 4'd6, 1);
    idle_drain();

    // Overflow past the signed DATA_W range
    step(0, '0, 1, 0, 0, '0, 1);
    step(1, lanes_big, 0, 0, 0, '0, 1);
    step(1, lanes_big, 0, 0, 0, '0, 1);
    step(0, '0, 0, 1, 0, 4'd0, 1);
    idle_drain();

    // Asynchronous reset while the second beat is stalled
    repeat (2) step(1, lanes_k1, 0, 0, 0, '0, 1);
    step(0, '0, 0, 1, 0, 4'd3, 1);
    step(0, '0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 0, '0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_store_ready", 64'(store_ready), 64'(1));
    chk("mid_rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    step(0, '0, 0, 1, 0, 4'd1, 1);
    idle_drain();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < ARR; k++)
        rnd[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      step(($urandom_range(0, 3) != 0), rnd, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 6) == 0), 1'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7));
    end
    idle_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
